// File: rtl/ohc9_accum_ctrl_pkg.sv
// Shared constants, FSM state type and residue helpers for the mod-9 one-hot accumulator.
// Residue 0 is bit 0 of the one-hot code; the code is never all-zero.
package ohc9_pkg;

  localparam int         MOD      = 9;
  localparam logic [8:0] OHC_ZERO = 9'b000000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operands arrive as 0..15; 9..15 fold once to 0..6.
  function automatic logic [3:0] bin_mod9(input logic [3:0] v);
    logic [3:0] r;
    r = (v >= 4'(MOD)) ? (v - 4'(MOD)) : v;
    return r;
  endfunction

  function automatic logic [3:0] ohc2bin(input logic [8:0] ohc);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < MOD; k++) begin
      if (ohc[k]) r = 4'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/ohc9_accum_ctrl_if.sv
// Operand stream, result handshake and status of the mod-9 accumulator.
// master = operand producer / result consumer, slave = the accumulator.
interface ohc9_accum_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [8:0]       res_ohc;
  logic [3:0]       res_bin;
  logic             busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, res_ohc, res_bin, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, res_ohc, res_bin, busy
  );
endinterface

// File: rtl/ohc9_accum_ctrl_rotate.sv
// Combinational 9-bit circular left rotate; a one-hot residue add by amt (0..8).
// Zero latency; no handshake.
module ohc9_rotate (
  input  logic [8:0] i_ohc,
  input  logic [3:0] i_amt,
  output logic [8:0] o_ohc
);

  logic [17:0] w_dbl;

  // Shifting a doubled copy lets the upper half pick up the wrapped bits.
  assign w_dbl = {i_ohc, i_ohc} << i_amt;
  assign o_ohc = w_dbl[17:9];

endmodule

// File: rtl/ohc9_accum_ctrl.sv
// Batch sequencer: sums a stream of operands mod 9 in one-hot form, returns OHC + binary residue.
// Result valid the cycle after the last accepted beat; held until out_ready.
module ohc9_accum_ctrl
  import ohc9_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  ohc9_accum_ctrl_if.slave  bus
);

  state_t           r_state;
  logic [8:0]       r_acc;
  logic [LEN_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [8:0]       r_res_ohc;
  logic [3:0]       r_res_bin;
  logic             r_busy;

  logic             w_beat;
  logic [3:0]       w_amt;
  logic [8:0]       w_rot;

  assign w_beat = bus.in_valid & r_in_ready;
  assign w_amt  = bin_mod9(bus.in_data);

  ohc9_rotate u_rotate (
    .i_ohc (r_acc),
    .i_amt (w_amt),
    .o_ohc (w_rot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= OHC_ZERO;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_res_ohc   <= OHC_ZERO;
      r_res_bin   <= 4'd0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc   <= OHC_ZERO;
            r_count <= bus.len;
            r_busy  <= 1'b1;
            if (bus.len != '0) begin
              r_state    <= ACCUM;
              r_in_ready <= 1'b1;
            end else begin
              // Empty batch: publish residue 0 without opening the operand port.
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_res_ohc   <= OHC_ZERO;
              r_res_bin   <= 4'd0;
            end
          end
        end

        ACCUM: begin
          if (w_beat) begin
            r_acc   <= w_rot;
            r_count <= r_count - 1'b1;
            if (r_count == LEN_W'(1)) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_res_ohc   <= w_rot;
              r_res_bin   <= ohc2bin(w_rot);
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.res_ohc   = r_res_ohc;
  assign bus.res_bin   = r_res_bin;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_ohc9_accum_ctrl.sv
// Directed bench for ohc9_accum_ctrl: drives and samples on the falling edge.
module tb_ohc9_accum_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ohc9_accum_ctrl_if #(.LEN_W(8)) bus ();

  ohc9_accum_ctrl #(.LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_batch(input logic [7:0] n);
    bus.start = 1'b1;
    bus.len   = n;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 8'd0;
  endtask

  task automatic send(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 4'd0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic [8:0] ohc, input logic [3:0] bin);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_res_ohc"},   32'(bus.res_ohc),   32'(ohc));
    check({tag, "_res_bin"},   32'(bus.res_bin),   32'(bin));
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_busy"},  32'(bus.busy),      32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_res_ohc"},   32'(bus.res_ohc),   32'h001);
    check({tag, "_res_bin"},   32'(bus.res_bin),   32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.len       = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'd0;
    bus.out_ready = 1'b0;
    idle_cycles(3);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset_idle");

    // 4+7+8 = 19 -> residue 1
    start_batch(8'd3);
    check("b1_in_ready", 32'(bus.in_ready), 32'd1);
    check("b1_busy",     32'(bus.busy),     32'd1);
    send(4'd4);
    send(4'd7);
    check("b1_no_early_valid", 32'(bus.out_valid), 32'd0);
    send(4'd8);
    check_result("b1", 9'b000000010, 4'd1);
    accept("b1");

    // Empty batch goes straight to DONE with residue 0.
    start_batch(8'd0);
    check_result("len0", 9'b000000001, 4'd0);
    check("len0_busy", 32'(bus.busy), 32'd1);
    accept("len0");

    // 15 folds to 6; 6+5 = 11 -> residue 2, with gaps between beats.
    start_batch(8'd2);
    send(4'd15);
    idle_cycles(3);
    check("gap_in_ready", 32'(bus.in_ready),  32'd1);
    check("gap_no_valid", 32'(bus.out_valid), 32'd0);
    send(4'd5);
    check_result("gap", 9'b000000100, 4'd2);
    accept("gap");

    // Result held under backpressure; start is ignored outside IDLE.
    start_batch(8'd1);
    send(4'd5);
    bus.start = 1'b1;
    bus.len   = 8'd0;
    for (int i = 0; i < 5; i++) begin
      check_result("hold", 9'b000100000, 4'd5);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_result("hold_end", 9'b000100000, 4'd5);
    accept("hold");

    // Reset mid-batch aborts it; next batch starts clean.
    start_batch(8'd4);
    send(4'd2);
    send(4'd3);
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("abort_idle");
    start_batch(8'd1);
    send(4'd3);
    check_result("after_abort", 9'b000001000, 4'd3);
    accept("after_abort");

    // Longest batch: 255 ones -> residue 3.
    start_batch(8'd255);
    for (int i = 0; i < 255; i++) begin
      check("long_onehot", 32'($onehot(bus.res_ohc)), 32'd1);
      send(4'd1);
    end
    check_result("long", 9'b000001000, 4'd3);
    accept("long");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
